// File: rtl/sdram_brst_seq_pkg.sv
// Shared constants, state encoding and BL decode for the SDRAM burst sequencer.
// The optional error flag is enabled with SDRAM_BRST_ERR_EN.
package sdram_brst_pkg;

    localparam logic [2:0] BL1    = 3'b000;
    localparam logic [2:0] BL2    = 3'b001;
    localparam logic [2:0] BL4    = 3'b010;
    localparam logic [2:0] BL8    = 3'b011;
    localparam logic [2:0] BLPAGE = 3'b111;

    localparam logic BT_SEQ = 1'b0;
    localparam logic BT_INT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_PAGE  = 2'd2
    } brst_state_e;

    // Bounded burst length in beats; reserved codes fall back to a single beat.
    function automatic logic [3:0] bl_code_to_len(input logic [2:0] code);
        logic [3:0] len;
        case (code)
            BL1:     len = 4'd1;
            BL2:     len = 4'd2;
            BL4:     len = 4'd4;
            BL8:     len = 4'd8;
            default: len = 4'd1;
        endcase
        return len;
    endfunction

    function automatic logic bl_code_reserved(input logic [2:0] code);
        return code[2] && (code != BLPAGE);
    endfunction

endpackage

// File: rtl/sdram_brst_seq_if.sv
// Command-side / datapath-side bundle of the burst sequencer.
// The brst_err signal exists only when SDRAM_BRST_ERR_EN is defined.
interface sdram_brst_seq_if #(
    parameter int COL_W = 9
);
    logic             ld_brst;
    logic [COL_W-1:0] start_col;
    logic [2:0]       brst_len;
    logic             brst_type;
    logic             brst_stop;
    logic             hold;

    logic [COL_W-1:0] col_addr;
    logic             brst_active;
    logic             brst_last;
    logic             brst_end;
    logic             brst_end_mN;
    logic [COL_W-1:0] beats_left;
`ifdef SDRAM_BRST_ERR_EN
    logic             brst_err;
`endif

    modport master (
`ifdef SDRAM_BRST_ERR_EN
        input  brst_err,
`endif
        output ld_brst, start_col, brst_len, brst_type, brst_stop, hold,
        input  col_addr, brst_active, brst_last, brst_end, brst_end_mN, beats_left
    );

    modport slave (
`ifdef SDRAM_BRST_ERR_EN
        output brst_err,
`endif
        input  ld_brst, start_col, brst_len, brst_type, brst_stop, hold,
        output col_addr, brst_active, brst_last, brst_end, brst_end_mN, beats_left
    );

endinterface

// File: rtl/sdram_brst_seq_col_next.sv
// Next column address inside a bounded burst: only the low log2(BL) bits move,
// by modular add (sequential) or XOR (interleaved); upper bits follow start_col.
module sdram_col_next
    import sdram_brst_pkg::*;
#(
    parameter int COL_W = 9
) (
    input  logic [COL_W-1:0] start_col,
    input  logic [2:0]       beat_idx,
    input  logic [3:0]       bl_len,
    input  logic             brst_type,
    output logic [COL_W-1:0] col_next
);

    logic [2:0] mask;
    logic [2:0] low_seq;
    logic [2:0] low_int;
    logic [2:0] low_sel;

    always_comb begin
        mask     = 3'(bl_len - 4'd1);
        low_seq  = start_col[2:0] + beat_idx;
        low_int  = start_col[2:0] ^ beat_idx;
        low_sel  = (brst_type == BT_INT) ? low_int : low_seq;
        col_next = start_col;
        col_next[2:0] = (start_col[2:0] & ~mask) | (low_sel & mask);
    end

endmodule

// File: rtl/sdram_brst_seq.sv
// Burst sequencer: beat countdown, early-warning flags and per-beat column address.
// Define SDRAM_BRST_ERR_EN to add the sticky brst_err flag for illegal load codes.
module sdram_brst_seq
    import sdram_brst_pkg::*;
#(
    parameter int COL_W = 9,
    parameter int EARLY = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    sdram_brst_seq_if.slave bus
);

    brst_state_e      state_q, state_d;
    logic [COL_W-1:0] col_addr_q, col_addr_d;
    logic [COL_W-1:0] beats_left_q, beats_left_d;
    logic [COL_W-1:0] start_col_q, start_col_d;
    logic [3:0]       bl_len_q, bl_len_d;
    logic             type_q, type_d;
    logic [2:0]       idx_q, idx_d;

    logic [3:0]       ld_len;
    logic             ld_page;
    logic             last_beat;
    logic             stop_hit;
    logic [COL_W-1:0] col_next;

    assign ld_len    = bl_code_to_len(bus.brst_len);
    assign ld_page   = (bus.brst_len == BLPAGE);
    assign last_beat = (state_q == ST_BURST) && (beats_left_q == '0);
    assign stop_hit  = bus.brst_stop && (state_q != ST_IDLE);

    sdram_col_next #(.COL_W(COL_W)) u_col_next (
        .start_col (start_col_q),
        .beat_idx  (idx_q + 3'd1),
        .bl_len    (bl_len_q),
        .brst_type (type_q),
        .col_next  (col_next)
    );

    // Load beats stop, stop beats hold, hold beats the normal count.
    always_comb begin
        state_d      = state_q;
        col_addr_d   = col_addr_q;
        beats_left_d = beats_left_q;
        start_col_d  = start_col_q;
        bl_len_d     = bl_len_q;
        type_d       = type_q;
        idx_d        = idx_q;

        if (bus.ld_brst) begin
            start_col_d = bus.start_col;
            col_addr_d  = bus.start_col;
            idx_d       = 3'd0;
            bl_len_d    = ld_len;
            if (ld_page) begin
                state_d      = ST_PAGE;
                type_d       = BT_SEQ;
                beats_left_d = '1;
            end else begin
                state_d      = ST_BURST;
                type_d       = bus.brst_type;
                beats_left_d = COL_W'(ld_len - 4'd1);
            end
        end else if (stop_hit) begin
            state_d = ST_IDLE;
        end else if (!bus.hold) begin
            case (state_q)
                ST_BURST: begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beats_left_d = beats_left_q - 1'b1;
                        idx_d        = idx_q + 3'd1;
                        col_addr_d   = col_next;
                    end
                end
                ST_PAGE:  col_addr_d = col_addr_q + 1'b1;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            col_addr_q   <= '0;
            beats_left_q <= '0;
            start_col_q  <= '0;
            bl_len_q     <= 4'd1;
            type_q       <= BT_SEQ;
            idx_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            col_addr_q   <= col_addr_d;
            beats_left_q <= beats_left_d;
            start_col_q  <= start_col_d;
            bl_len_q     <= bl_len_d;
            type_q       <= type_d;
            idx_q        <= idx_d;
        end
    end

    assign bus.col_addr    = col_addr_q;
    assign bus.beats_left  = beats_left_q;
    assign bus.brst_active = (state_q != ST_IDLE);
    assign bus.brst_end    = (state_q == ST_IDLE);
    assign bus.brst_last   = last_beat || stop_hit;
    assign bus.brst_end_mN = (state_q == ST_BURST) && (beats_left_q == COL_W'(EARLY));

`ifdef SDRAM_BRST_ERR_EN
    logic err_q, err_d;

    // Sticky until reset so firmware can spot a bad mode-register setup after the fact.
    always_comb begin
        err_d = err_q;
        if (bus.ld_brst && (bl_code_reserved(bus.brst_len) || (ld_page && bus.brst_type == BT_INT)))
            err_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.brst_err = err_q;
`endif

endmodule

// File: doc/sdram_brst_seq.md
Name: sdram_brst_seq

Overview:
- Parametrised burst sequencer for the SDRAM controller.
- Loads a burst and counts beats down to zero, providing burst-end and programmable early-warning flags.
- Generates the per-beat column address using JEDEC sequential or interleaved ordering, with wrap-around.
- Sits between the command state machine and the address/data path; replaces the fixed 3-bit burst counter.

Parameters:
- COL_W, 9, column address width; full-page length = 2^COL_W beats.
- EARLY, 1, lookahead for brst_end_mN; legal range 1..7.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- ld_brst  in  1  load/start burst (single-cycle pulse).
- start_col  in  COL_W  starting column address, sampled on ld_brst.
- brst_len  in  3  mode-register BL code: 000=1, 001=2, 010=4, 011=8, 111=full page; 100..110 reserved.
- brst_type  in  1  0=sequential, 1=interleaved; sampled on ld_brst.
- brst_stop  in  1  burst terminate.
- hold  in  1  stall: freezes count and address.
- col_addr  out  COL_W  current beat column address (registered).
- brst_active  out  1  burst in progress.
- brst_last  out  1  current beat is the final beat.
- brst_end  out  1  idle / burst finished (legacy semantics).
- brst_end_mN  out  1  EARLY beats remain after the current beat.
- beats_left  out  COL_W  remaining beats after the current one.

Behaviour:
- Clock/reset: clock Clk; reset Reset, asynchronous, active-low.
- Reset values: col_addr=0, beats_left=0, brst_active=0, brst_last=0, brst_end=1, brst_end_mN=0.
- States: IDLE, BURST, PAGE (full-page, unbounded).
- Load (ld_brst=1), in any state:
  - latch start_col, brst_type, BL.
  - col_addr <= start_col next cycle.
  - beats_left <= BL-1.
  - go to BURST; if code 111, go to PAGE.
  - Reserved codes act as BL=1.
  - Interleaved + full page acts as sequential.
- BURST, per cycle with hold=0:
  - beats_left decrements.
  - beat index i increments.
  - If beats_left==0 in the current cycle, the beat is last: return to IDLE next cycle.
- Sequential addressing:
  - col_addr[k-1:0] = (start_col[k-1:0] + i) mod BL, where k = log2(BL).
  - Upper bits are held at start_col.
- Interleaved addressing: col_addr[k-1:0] = start_col[k-1:0] XOR i; upper bits held.
- PAGE:
  - col_addr increments mod 2^COL_W, wrapping 2^COL_W-1 -> 0.
  - Runs until brst_stop.
  - beats_left is held at 2^COL_W-1; brst_last and brst_end_mN stay 0.
- brst_stop in BURST/PAGE: the current beat is final; IDLE next cycle; brst_last=1 this cycle (combinational with stop).
- Flag equations:
  - brst_active = state!=IDLE.
  - brst_end = state==IDLE.
  - brst_last = BURST & beats_left==0 (or stop).
  - brst_end_mN = BURST & beats_left==EARLY.
- Hold: col_addr, beats_left and state are frozen; flags are recomputed from the frozen values.
- Priority: ld_brst > brst_stop > hold > count.
- Edge cases:
  - ld_brst on a last beat starts the new burst back-to-back with no idle cycle.
  - BL=1: brst_last is high on the first beat; brst_end_mN never asserts for EARLY>=1.
  - Reset mid-burst: immediately returns to reset values.

Optional Feature:
- Macro SDRAM_BRST_ERR_EN.
- When defined:
  - adds output brst_err (1 bit), reset 0.
  - brst_err is sticky-set on ld_brst with a reserved code, or with interleaved + full page.
  - cleared only by Reset.
- When undefined: no port and no logic; the fallback behaviour above is unchanged.

Decomposition:
- Package sdram_brst_pkg:
  - BL code constants (BL1, BL2, BL4, BL8, BLPAGE).
  - BT_SEQ/BT_INT.
  - state encoding.
  - function bl_code_to_len.
- One sub-module, sdram_col_next: combinational next-column calculation from (start_col, i, BL, type).

Test Plan:
- Reset asserted mid-PAGE burst -> all outputs at reset values asynchronously, brst_end=1.
- ld BL=4 seq, start_col=0x006 -> col_addr 006,007,004,005; brst_end_mN (EARLY=1) on beat 3; brst_last on beat 4; brst_end=1 after.
- ld BL=8 interleaved, start_col=0x013 -> low bits 3,2,1,0,7,6,5,4, upper bits 0x010 held; hold asserted 2 cycles at beat 2 -> address frozen, 8 beats total.
- ld full page, start_col=0x1FE -> 1FE,1FF,000,001; brst_stop on 001 -> brst_last same cycle, IDLE next.
- BL=2 back-to-back: ld on the last beat -> no idle cycle; new start_col appears next cycle; brst_end stays 0.
- ld brst_len=101 with SDRAM_BRST_ERR_EN -> single-beat burst, brst_err=1 and stays set until Reset.
